// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding scoreboard.
// Each in-flight register write is tracked as one fwd_entry_t tag.
package fwd_pkg;

    // Widest register address a tag can hold; narrower addresses are zero-extended.
    localparam int MAX_REG_AW = 8;

    // A select of zero means the operand is read from the register file.
    localparam int SEL_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] rd;
        logic                  regwrite;
        logic                  load;
    } fwd_entry_t;

    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher for one source operand against the in-flight tag array.
// Produces a forward select, or a hazard when the youngest match is not ready.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_READY = 1,
    parameter int REG_AW     = 5,
    localparam int SEL_W     = sel_w(FWD_DEPTH)
) (
    input  fwd_entry_t [FWD_DEPTH-1:0] entries_i,
    input  logic [REG_AW-1:0]          src_i,
    input  logic                       ex_valid_i,
    output logic [SEL_W-1:0]           sel_o,
    output logic                       hazard_o
);

    logic [MAX_REG_AW-1:0] src_ext;

    assign src_ext = MAX_REG_AW'(src_i);

    // Scan oldest to youngest so the youngest match overwrites; a non-ready
    // younger match therefore masks any older ready one.
    always_comb begin
        sel_o    = SEL_W'(SEL_RF);
        hazard_o = 1'b0;
        if (ex_valid_i && (src_ext != '0)) begin
            for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
                if (entries_i[k].valid && entries_i[k].regwrite &&
                    (entries_i[k].rd == src_ext)) begin
                    if (!entries_i[k].load || (k >= LOAD_READY)) begin
                        sel_o    = SEL_W'(FWD_DEPTH - k);
                        hazard_o = 1'b0;
                    end else begin
                        sel_o    = SEL_W'(SEL_RF);
                        hazard_o = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight writes in a tag shift register and
// derives per-source forward selects, a load-use stall and saturating statistics.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_READY = 1,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = sel_w(FWD_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      flush_i,
    input  logic                      ex_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src_i,
    input  logic [REG_AW-1:0]         ex_rd_i,
    input  logic                      ex_regwrite_i,
    input  logic                      ex_memread_i,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
    output logic                      stall_o,
    output logic [CNT_W-1:0]          fwd_cnt_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    fwd_entry_t [FWD_DEPTH-1:0] entries_q, entries_d;
    logic [NUM_SRC-1:0]         hazard;
    logic                       fwd_any;
    logic [CNT_W-1:0]           fwd_cnt_q, fwd_cnt_d;
    logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_match #(
            .FWD_DEPTH  (FWD_DEPTH),
            .LOAD_READY (LOAD_READY),
            .REG_AW     (REG_AW)
        ) u_match (
            .entries_i  (entries_q),
            .src_i      (ex_src_i[s*REG_AW +: REG_AW]),
            .ex_valid_i (ex_valid_i),
            .sel_o      (fwd_sel_o[s*SEL_W +: SEL_W]),
            .hazard_o   (hazard[s])
        );
    end

    assign stall_o = ex_valid_i && (|hazard);
    assign fwd_any = |fwd_sel_o;

    // A stalled or flushed EX instruction leaves a bubble behind while older
    // tags keep ageing, which is what lets a pending load become ready.
    always_comb begin
        entries_d = entries_q;
        if (en_i) begin
            for (int i = FWD_DEPTH - 1; i >= 1; i--) begin
                entries_d[i] = entries_q[i-1];
            end
            entries_d[0] = '0;
            if (ex_valid_i && !stall_o && !flush_i) begin
                entries_d[0].valid    = 1'b1;
                entries_d[0].rd       = MAX_REG_AW'(ex_rd_i);
                entries_d[0].regwrite = ex_regwrite_i;
                entries_d[0].load     = ex_memread_i;
            end
        end
    end

    always_comb begin
        fwd_cnt_d   = fwd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (en_i && fwd_any && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + 1'b1;
        end
        if (en_i && stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entries_q   <= '0;
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            entries_q   <= entries_d;
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_cnt_o   = fwd_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the pipeline forwarding unit. It tracks in-flight register writes in an internal tag pipeline instead of taking stage-register fields as inputs.
- Produces a forward select per source operand of the EX-stage instruction, plus a load-use stall when the matching producer's data is not yet available.
- Sits beside the ALU operand muxes. Keeps saturating statistics counters for forwards and stalls.

Parameters:
- NUM_SRC, 2: source operands per instruction.
- FWD_DEPTH, 2: post-EX stages able to forward. Entry 0 = EX/MEM, entry 1 = MEM/WB, and so on.
- LOAD_READY, 1: lowest entry index at which a load's data is forwardable.
- REG_AW, 5: register address width.
- CNT_W, 16: statistics counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- en_i  in  1  pipeline advance enable; low freezes all state.
- flush_i  in  1  squash the EX instruction; a bubble enters entry 0.
- ex_valid_i  in  1  EX holds a real instruction.
- ex_src_i  in  NUM_SRC*REG_AW  EX source registers; source s is at bits [s*REG_AW +: REG_AW].
- ex_rd_i  in  REG_AW  EX destination register.
- ex_regwrite_i  in  1  EX instruction writes ex_rd_i.
- ex_memread_i  in  1  EX instruction is a load.
- fwd_sel_o  out  NUM_SRC*SEL_W  per-source select, with SEL_W = clog2(FWD_DEPTH+1).
- stall_o  out  1  load-use hazard; EX must hold.
- fwd_cnt_o  out  CNT_W  cycles with at least one nonzero select.
- stall_cnt_o  out  CNT_W  cycles with stall_o high.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Entry contents: FWD_DEPTH entries, each holding {valid, rd, regwrite, load}.
- Entry readiness: an entry is ready if load==0, or if its index >= LOAD_READY.
- Reset: all entry valid bits are 0 and both counters are 0. As a result fwd_sel_o=0 and stall_o=0 in the cycle after reset.
- Reset mid-operation discards all in-flight tags; there is no partial retention.
- Per-source match, combinational and zero latency from ex_src_i:
  - If src==0, or ex_valid_i==0, the select is 0.
  - Otherwise take the lowest-index (youngest) entry k with valid && regwrite && rd==src && rd!=0.
  - If k is ready, the select is FWD_DEPTH-k. With defaults this gives EX/MEM=2'b10 and MEM/WB=2'b01, matching the legacy encoding.
  - If k is not ready, the select is 0 and the source raises a hazard.
  - If no entry matches, the select is 0 (register file value).
- Younger-match priority: a younger non-ready match masks any older ready match. The result is a stall, not a stale forward.
- stall_o is the OR of all source hazards, gated by ex_valid_i.
- Shift, on a rising edge with en_i=1 and rst_i=0:
  - entry[i] takes entry[i-1] for i>=1. The oldest entry drops out, meaning it is retired to the register file.
  - entry0 takes {1, ex_rd_i, ex_regwrite_i, ex_memread_i} when ex_valid_i && !stall_o && !flush_i.
  - Otherwise entry0 takes a bubble (valid=0).
- Stall case: the bubble enters entry 0 while the load moves one entry older. The hazard therefore clears after at most LOAD_READY cycles of en_i.
- en_i=0: no shift, flush_i is ignored, counters hold, and outputs are still computed from the frozen state.
- Simultaneous flush_i and stall_o: the bubble is inserted and the stall counter still increments.
- Counters:
  - fwd_cnt_o increments on en_i cycles when any select is nonzero.
  - stall_cnt_o increments on en_i cycles when stall_o is high.
  - Both saturate at all-ones and do not wrap.
- No write-after-write ambiguity: only the youngest match is used.

Decomposition:
- Package fwd_pkg holds:
  - the entry struct typedef fwd_entry_t;
  - the function sel_w(depth) returning clog2(depth+1);
  - the constant SEL_RF = 0.
- Sub-module fwd_match: one source's priority matcher over the entry array, returning {sel, hazard}. It is instantiated NUM_SRC times with a generate loop.
- The top level holds the tag shift register, the stall OR and the counters.

Test Plan:
- Defaults: issue add r3 (regwrite); next cycle EX src0=r3 -> fwd_sel src0=2'b10. One cycle later with no new writer to r3 -> 2'b01. Next cycle -> 2'b00.
- Issue lw r5; next cycle EX src1=r5 -> stall_o=1 and stall_cnt_o=1. Next en_i cycle -> stall_o=0 and src1 select=2'b01.
- Two writers to r7 in consecutive cycles; EX src0=r7 -> select=2'b10 (youngest wins). Also: rd=r0 with regwrite, src=r0 -> select=0.
- Flush: issue add r4 with flush_i=1; next cycle src0=r4 -> select 0. Also: en_i=0 for 3 cycles -> selects and counters unchanged.
- Assert rst_i while a load is in entry 0 -> next cycle stall_o=0, selects 0, counters 0.
- NUM_SRC=3, FWD_DEPTH=3, LOAD_READY=2:
  - match in entry 2 -> select 1; match in entry 0 -> select 3;
  - load in entry 0 -> stall for 2 en_i cycles, then select=1;
  - preset fwd_cnt_o to all-ones -> holds at all-ones.
